// File: rtl/image_scaler.sv
// image_scaler: walks every destination pixel, reads 1 or 4 source pixels from a synchronous ROM, writes one framebuffer pixel.
// Build option: define SCALER_AVG_EN to compile the 2x2 block-average mode; otherwise mode 10 behaves as decimate.
module image_scaler #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 17,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    output logic [SRC_AW-1:0] R_ADDR,
    input  logic [PIX_W-1:0]  PIXEL_IN,
    output logic [DST_AW-1:0] W_ADDR,
    output logic [PIX_W-1:0]  PIXEL_OUT,
    output logic              WREN,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CW = (2 * SRC_W > 2) ? $clog2(2 * SRC_W) : 1;
    localparam int RW = (2 * SRC_H > 2) ? $clog2(2 * SRC_H) : 1;
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [CW-1:0]     dx_q;
    logic [RW-1:0]     dy_q;
    logic [SRC_AW-1:0] base_q;
    logic [SRC_AW-1:0] col_q;
    logic              xo_q;
    logic              yo_q;
    logic [1:0]        samp_q;
    logic [WW-1:0]     wait_q;
    logic              last_q;

    logic [CW-1:0]     dx_last;
    logic [RW-1:0]     dy_last;
    logic [SRC_AW-1:0] col_step;
    logic [SRC_AW-1:0] row_step;
    logic [SRC_AW-1:0] rd_addr_nx;
    logic              last_samp;
    logic [PIX_W-1:0]  pix_res;

    // Offset of sample s inside a 2x2 block: bit0 selects the right column, bit1 the lower row.
    function automatic logic [SRC_AW-1:0] sample_off(input logic [1:0] s);
        logic [SRC_AW-1:0] off;
        off = s[0] ? SRC_AW'(1) : '0;
        if (s[1]) off = off + SRC_AW'(SRC_W);
        return off;
    endfunction

`ifdef SCALER_AVG_EN
    logic [PIX_W+1:0] acc_q;
    logic [PIX_W+1:0] sum;

    // Round-to-nearest average; the +2 cannot overflow PIX_W+2 bits.
    function automatic logic [PIX_W-1:0] round_avg(input logic [PIX_W+1:0] s);
        logic [PIX_W+1:0] r;
        r = s + (PIX_W+2)'(2);
        return r[PIX_W+1:2];
    endfunction
`endif

    always_comb begin
        dx_last  = CW'(SRC_W - 1);
        dy_last  = RW'(SRC_H - 1);
        col_step = SRC_AW'(1);
        row_step = SRC_AW'(SRC_W);
        case (mode_q)
            2'b00: begin
                dx_last  = CW'(2 * SRC_W - 1);
                dy_last  = RW'(2 * SRC_H - 1);
                col_step = {{(SRC_AW-1){1'b0}}, xo_q};
                row_step = yo_q ? SRC_AW'(SRC_W) : '0;
            end
            2'b01, 2'b10: begin
                dx_last  = CW'(SRC_W / 2 - 1);
                dy_last  = RW'(SRC_H / 2 - 1);
                col_step = SRC_AW'(2);
                row_step = SRC_AW'(2 * SRC_W);
            end
            default: ;
        endcase
        rd_addr_nx = base_q + col_q + sample_off(samp_q + 2'd1);
    end

    always_comb begin
`ifdef SCALER_AVG_EN
        sum       = ((samp_q == 2'd0) ? '0 : acc_q) + {2'b00, PIXEL_IN};
        last_samp = (mode_q != 2'b10) || (samp_q == 2'd3);
        pix_res   = (mode_q == 2'b10) ? round_avg(sum) : PIXEL_IN;
`else
        last_samp = 1'b1;
        pix_res   = PIXEL_IN;
`endif
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            base_q    <= '0;
            col_q     <= '0;
            xo_q      <= 1'b0;
            yo_q      <= 1'b0;
            samp_q    <= '0;
            wait_q    <= '0;
            last_q    <= 1'b0;
`ifdef SCALER_AVG_EN
            acc_q     <= '0;
`endif
            R_ADDR    <= '0;
            W_ADDR    <= '0;
            PIXEL_OUT <= '0;
            WREN      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
`ifdef SCALER_AVG_EN
                        mode_q <= ALGORITHM;
`else
                        mode_q <= (ALGORITHM == 2'b10) ? 2'b01 : ALGORITHM;
`endif
                        dx_q    <= '0;
                        dy_q    <= '0;
                        base_q  <= '0;
                        col_q   <= '0;
                        xo_q    <= 1'b0;
                        yo_q    <= 1'b0;
                        samp_q  <= '0;
                        last_q  <= 1'b0;
                        R_ADDR  <= '0;
                        W_ADDR  <= '0;
                        BUSY    <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    wait_q  <= WW'(RD_LAT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WW'(1);
                    end else if (!last_samp) begin
`ifdef SCALER_AVG_EN
                        acc_q <= sum;
`endif
                        samp_q  <= samp_q + 2'd1;
                        R_ADDR  <= rd_addr_nx;
                        state_q <= S_READ;
                    end else begin
                        PIXEL_OUT <= pix_res;
                        WREN      <= 1'b1;
                        samp_q    <= '0;
                        last_q    <= (dx_q == dx_last) && (dy_q == dy_last);
                        state_q   <= S_WRITE;
                        // Advance the destination walk now so WRITE can issue the next read address.
                        if (dx_q == dx_last) begin
                            dx_q   <= '0;
                            col_q  <= '0;
                            xo_q   <= 1'b0;
                            yo_q   <= ~yo_q;
                            dy_q   <= dy_q + RW'(1);
                            base_q <= base_q + row_step;
                        end else begin
                            dx_q  <= dx_q + CW'(1);
                            col_q <= col_q + col_step;
                            xo_q  <= ~xo_q;
                        end
                    end
                end
                S_WRITE: begin
                    WREN <= 1'b0;
                    if (last_q) begin
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        W_ADDR  <= W_ADDR + DST_AW'(1);
                        R_ADDR  <= base_q + col_q;
                        state_q <= S_READ;
                    end
                end
                S_FIN: begin
                    DONE    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_scaler.sv
// Bench for image_scaler on a 4x4 source: directed and random frames checked against an arithmetic model.
module tb_image_scaler;

    localparam int SW  = 4;
    localparam int SH  = 4;
    localparam int PW  = 8;
    localparam int SAW = 4;
    localparam int DAW = 6;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           RESET = 1'b0;
    logic           START = 1'b0;
    logic [1:0]     ALGORITHM = 2'b00;
    logic [SAW-1:0] R_ADDR;
    logic [PW-1:0]  PIXEL_IN = '0;
    logic [DAW-1:0] W_ADDR;
    logic [PW-1:0]  PIXEL_OUT;
    logic           WREN;
    logic           BUSY;
    logic           DONE;

    image_scaler #(
        .SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .SRC_AW(SAW), .DST_AW(DAW), .RD_LAT(LAT)
    ) dut (
        .CLK(clk), .RESET(RESET), .START(START), .ALGORITHM(ALGORITHM),
        .R_ADDR(R_ADDR), .PIXEL_IN(PIXEL_IN), .W_ADDR(W_ADDR), .PIXEL_OUT(PIXEL_OUT),
        .WREN(WREN), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] src_mem [SW*SH];

    // One-cycle synchronous ROM.
    always @(posedge clk) PIXEL_IN <= src_mem[R_ADDR];

    logic [DAW-1:0] wa_q[$];
    logic [PW-1:0]  wd_q[$];
    int             done_cnt = 0;
    bit             b2b = 1'b0;
    bit             nobusy = 1'b0;
    logic           prev_wren = 1'b0;

    always @(negedge clk) begin
        if (WREN) begin
            wa_q.push_back(W_ADDR);
            wd_q.push_back(PIXEL_OUT);
            if (!BUSY) nobusy = 1'b1;
        end
        if (WREN && prev_wren) b2b = 1'b1;
        if (DONE) done_cnt++;
        prev_wren = WREN;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic bit avg_built();
`ifdef SCALER_AVG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int dst_w(input logic [1:0] m);
        case (m)
            2'd0:    return 2 * SW;
            2'd1,
            2'd2:    return SW / 2;
            default: return SW;
        endcase
    endfunction

    function automatic int npix(input logic [1:0] m);
        case (m)
            2'd0:    return 4 * SW * SH;
            2'd1,
            2'd2:    return (SW / 2) * (SH / 2);
            default: return SW * SH;
        endcase
    endfunction

    function automatic int per_pix(input logic [1:0] m);
        return (m == 2'd2 && avg_built()) ? 4 * (1 + LAT) + 1 : (1 + LAT) + 1;
    endfunction

    function automatic logic [PW-1:0] model(input logic [1:0] m, input int i);
        int dw, dx, dy, s;
        dw = dst_w(m);
        dx = i % dw;
        dy = i / dw;
        case (m)
            2'd0: return src_mem[(dy / 2) * SW + dx / 2];
            2'd1: return src_mem[2 * dy * SW + 2 * dx];
            2'd2: begin
                if (!avg_built()) return src_mem[2 * dy * SW + 2 * dx];
                s = int'(src_mem[2*dy*SW + 2*dx]) + int'(src_mem[2*dy*SW + 2*dx + 1])
                  + int'(src_mem[(2*dy+1)*SW + 2*dx]) + int'(src_mem[(2*dy+1)*SW + 2*dx + 1]);
                return PW'((s + 2) / 4);
            end
            default: return src_mem[dy * SW + dx];
        endcase
    endfunction

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        b2b = 1'b0;
        nobusy = 1'b0;
    endtask

    // Runs one frame; if disturb>0, a stray START and an ALGORITHM change are applied at that cycle.
    task automatic run_frame(input logic [1:0] m, input int disturb);
        int cyc, n, lim;
        clear_mon();
        ALGORITHM = m;
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check("busy_first_read", BUSY, 1);
        n   = npix(m);
        lim = n * per_pix(m) + 50;
        cyc = 0;
        while (!DONE && cyc < lim) begin
            @(negedge clk);
            cyc++;
            if (disturb > 0 && cyc == disturb) begin
                START = 1'b1;
                ALGORITHM = ~m;
            end
            if (disturb > 0 && cyc == disturb + 1) START = 1'b0;
        end
        check("frame_cycles", cyc, n * per_pix(m));
        check("busy_low_at_done", BUSY, 0);
        @(negedge clk);
        #1;
        ALGORITHM = m;
        check("done_one_cycle", DONE, 0);
        check("done_pulse_count", done_cnt, 1);
        check("write_count", wa_q.size(), n);
        check("no_back_to_back_wren", b2b, 0);
        check("busy_during_writes", nobusy, 0);
        for (int i = 0; i < wa_q.size(); i++) begin
            check("w_addr_seq", wa_q[i], i);
            check("pixel_out", wd_q[i], model(m, i));
        end
    endtask

    initial begin
        int cyc;
        for (int a = 0; a < SW * SH; a++) src_mem[a] = PW'(a);

        // Reset held with START high.
        RESET = 1'b0;
        START = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wren", WREN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_r_addr", R_ADDR, 0);
        check("rst_w_addr", W_ADDR, 0);
        check("rst_pixel_out", PIXEL_OUT, 0);
        START = 1'b0;
        RESET = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", BUSY, 0);
        check("idle_writes", wa_q.size(), 0);

        // Zoom-in with src(a)=a.
        run_frame(2'd0, 0);
        check("zoom_waddr11", wd_q[11], 1);
        check("zoom_waddr31", wd_q[31], 7);

        // Decimate and copy with src(a)=a.
        run_frame(2'd1, 0);
        check("dec_px0", wd_q[0], 0);
        check("dec_px1", wd_q[1], 2);
        check("dec_px2", wd_q[2], 8);
        check("dec_px3", wd_q[3], 10);
        run_frame(2'd3, 0);

        // Block average on a known 2x2 corner.
        src_mem[0] = 8'd10;
        src_mem[1] = 8'd20;
        src_mem[4] = 8'd30;
        src_mem[5] = 8'd41;
        run_frame(2'd2, 0);
        check("avg_corner", wd_q[0], avg_built() ? 25 : 10);

        // Saturated block average must not overflow.
        for (int a = 0; a < SW * SH; a++) src_mem[a] = 8'hFF;
        run_frame(2'd2, 0);

        // Stray START and mode change mid-frame are ignored.
        for (int a = 0; a < SW * SH; a++) src_mem[a] = PW'($urandom);
        run_frame(2'd1, 5);
        run_frame(2'd0, 7);

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            for (int a = 0; a < SW * SH; a++) src_mem[a] = PW'($urandom);
            run_frame(2'($urandom_range(0, 3)), 0);
        end

        // Asynchronous reset during the 5th write of a zoom-in frame.
        clear_mon();
        ALGORITHM = 2'd0;
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        cyc = 0;
        while (wa_q.size() < 5 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("reached_5th_write", wa_q.size(), 5);
        check("wren_in_5th_write", WREN, 1);
        RESET = 1'b0;
        #1;
        check("async_rst_wren", WREN, 0);
        check("async_rst_busy", BUSY, 0);
        check("async_rst_w_addr", W_ADDR, 0);
        check("async_rst_pixel_out", PIXEL_OUT, 0);
        @(negedge clk);
        RESET = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("no_writes_after_rst", wa_q.size(), 5);
        check("no_done_after_rst", done_cnt, 0);
        run_frame(2'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
